// File: rtl/cpu_pkg.sv
// Shared constants for the MEM stage: control-bit positions, FSM encodings, NOP control.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Bit positions inside the 4-bit {RegWrite, MemtoReg, MemRead, MemWrite} control word
  localparam int CTL_REGWRITE = 3;
  localparam int CTL_MEMTOREG = 2;
  localparam int CTL_MEMREAD  = 1;
  localparam int CTL_MEMWRITE = 0;

  // Memory-request FSM encodings
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Control word of a bubble
  localparam logic [3:0] CTL_NOP = 4'b0000;

  // True when the control word asks for a data-memory access
  function automatic logic is_memop(input logic [3:0] ctrl);
    return ctrl[CTL_MEMREAD] | ctrl[CTL_MEMWRITE];
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
// Latency: n/a (wires only).
// Backpressure: memory holds off completion by withholding mem_ack_i.
interface mem_access_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_req_fsm.sv
// IDLE/ACCESS sequencer for one outstanding data-memory request; drives stall and mem_req.
// Latency: request rises the edge after issue, drops the edge after ack.
// Backpressure: stall is held from issue until the ack cycle; an issued request cannot be cancelled.
module mem_req_fsm
  import cpu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue,
  input  logic mem_ack,
  output logic stall,
  output logic mem_req,
  output logic in_access
);

  logic [0:0] state_q;
  logic [0:0] state_d;

  // Next state: leave IDLE on an issued op, return on ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (issue)   state_d = ST_ACCESS;
      ST_ACCESS: if (mem_ack) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // State and registered request; reset abandons any transaction in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      mem_req <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_req <= (state_d == ST_ACCESS);
    end
  end

  assign in_access = (state_q == ST_ACCESS);

  // Held low in reset so upstream is never frozen by stale inputs
  assign stall = rst_i & ((~in_access & issue) | (in_access & ~mem_ack));

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: runs loads/stores over a req/ack memory bus, registers results for MEM/WB.
// Latency: non-memory ops 1 cycle; memory ops 2 cycles minimum, +1 per memory wait cycle.
// Backpressure: stall_o holds upstream while an access is outstanding. Optional MEM_MISALIGN_TRAP_EN.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [3:0]        Control_i,
  input  logic [31:0]       Instruction_i,
  input  logic [DATA_W-1:0] ALU_i,
  input  logic [DATA_W-1:0] WriteData_i,
  input  logic [4:0]        RDaddr_i,
  output logic              stall_o,
  mem_access_stage_if.master mem,
  output logic              valid_o,
  output logic [1:0]        Control_o,
  output logic [31:0]       Instruction_o,
  output logic [DATA_W-1:0] Memory_o,
  output logic [DATA_W-1:0] ALU_o,
  output logic [4:0]        RDaddr_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  logic memop;
  logic misalign;
  logic issue;
  logic in_access;

  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [4:0]        rd_q;
  logic [1:0]        ctrl_q;
  logic [31:0]       instr_q;

  assign memop = valid_i & is_memop(Control_i);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = memop & (ALU_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Only a live, unflushed, aligned memory op starts a bus transaction
  assign issue = memop & ~flush_i & ~misalign;

  mem_req_fsm u_fsm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .issue     (issue),
    .mem_ack   (mem.mem_ack_i),
    .stall     (stall_o),
    .mem_req   (mem.mem_req_o),
    .in_access (in_access)
  );

  // Capture the request fields when an access is launched from IDLE; held until ack
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alu_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      instr_q <= '0;
    end else if (issue & ~in_access) begin
      alu_q   <= ALU_i;
      wdata_q <= WriteData_i;
      we_q    <= Control_i[CTL_MEMWRITE];  // store wins if both read and write are set
      rd_q    <= RDaddr_i;
      ctrl_q  <= Control_i[CTL_REGWRITE:CTL_MEMTOREG];
      instr_q <= Instruction_i;
    end
  end

  assign mem.mem_we_o    = we_q;
  assign mem.mem_wdata_o = wdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mem.mem_addr_o  = alu_q[ADDR_W-1:0];
`else
  // Word-aligned bus: the byte offset never reaches the memory
  assign mem.mem_addr_o  = {alu_q[ADDR_W-1:2], 2'b00};
`endif

  // MEM/WB output bank: completed accesses, pass-through ops, or bubbles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o       <= 1'b0;
      Control_o     <= '0;
      Instruction_o <= '0;
      Memory_o      <= '0;
      ALU_o         <= '0;
      RDaddr_o      <= '0;
    end else if (in_access) begin
      if (mem.mem_ack_i) begin
        valid_o       <= 1'b1;
        Control_o     <= ctrl_q;
        Instruction_o <= instr_q;
        Memory_o      <= we_q ? '0 : mem.mem_rdata_i;
        ALU_o         <= alu_q;
        RDaddr_o      <= rd_q;
      end else begin
        valid_o   <= 1'b0;
        Control_o <= CTL_NOP[CTL_REGWRITE:CTL_MEMTOREG];
      end
    end else if (valid_i & ~flush_i & ~issue) begin
      // Non-memory op, or a trapped misaligned op with its register write suppressed
      valid_o       <= 1'b1;
      Control_o     <= {Control_i[CTL_REGWRITE] & ~misalign, Control_i[CTL_MEMTOREG]};
      Instruction_o <= Instruction_i;
      Memory_o      <= '0;
      ALU_o         <= ALU_i;
      RDaddr_o      <= RDaddr_i;
    end else begin
      valid_o   <= 1'b0;
      Control_o <= CTL_NOP[CTL_REGWRITE:CTL_MEMTOREG];
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle trap flag alongside the suppressed result
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) misalign_o <= 1'b0;
    else        misalign_o <= ~in_access & misalign & ~flush_i;
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: reset, pass-through, load/store latency, flush, misalignment.
// Drives inputs 1 time unit after the rising edge and samples there or 1 unit later.
// Memory side is modelled by directed ack/rdata pulses on the interface.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic        flush_i;
  logic [3:0]  ctrl;
  logic [31:0] instr;
  logic [31:0] alu;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        stall_o;
  logic        valid_o;
  logic [1:0]  ctrl_o;
  logic [31:0] instr_o;
  logic [31:0] mem_o;
  logic [31:0] alu_o;
  logic [4:0]  rd_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int total = 0;
  int bad   = 0;
  int n;

  mem_access_stage_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .flush_i       (flush_i),
    .Control_i     (ctrl),
    .Instruction_i (instr),
    .ALU_i         (alu),
    .WriteData_i   (wdata),
    .RDaddr_i      (rd),
    .stall_o       (stall_o),
    .mem           (mif.master),
    .valid_o       (valid_o),
    .Control_o     (ctrl_o),
    .Instruction_o (instr_o),
    .Memory_o      (mem_o),
    .ALU_o         (alu_o),
    .RDaddr_o      (rd_o)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] r, input logic [31:0] ins);
    valid_i = v;
    flush_i = f;
    ctrl    = c;
    alu     = a;
    wdata   = wd;
    rd      = r;
    instr   = ins;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    rst_i           = 1'b0;
    mif.mem_ack_i   = 1'b0;
    mif.mem_rdata_i = 32'h0;
    nop();
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_req", 32'(mif.mem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_mem", mem_o, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_misalign", 32'(misalign_o), 32'd0);
`endif
    tick();
    tick();
    rst_i = 1'b1;
    tick();

    // 1: reset while a load is outstanding
    drive(1'b1, 1'b0, 4'b1110, 32'h0000_0080, 32'h0, 5'd3, 32'h0800_2183);
    tick();
    chk("t1_req_up", 32'(mif.mem_req_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t1_req_rst", 32'(mif.mem_req_o), 32'd0);
    chk("t1_stall_rst", 32'(stall_o), 32'd0);
    chk("t1_valid_rst", 32'(valid_o), 32'd0);
    nop();
    tick();
    rst_i = 1'b1;
    tick();
    mif.mem_ack_i   = 1'b1;
    mif.mem_rdata_i = 32'h5555_5555;
    #1;
    chk("t1_late_ack_stall", 32'(stall_o), 32'd0);
    tick();
    mif.mem_ack_i = 1'b0;
    chk("t1_late_ack_valid", 32'(valid_o), 32'd0);
    chk("t1_late_ack_req", 32'(mif.mem_req_o), 32'd0);

    // 2: ALU op passes through in one cycle
    drive(1'b1, 1'b0, 4'b1000, 32'h0000_0010, 32'h0, 5'd5, 32'h0050_82B3);
    #1;
    chk("t2_stall", 32'(stall_o), 32'd0);
    tick();
    nop();
    chk("t2_valid", 32'(valid_o), 32'd1);
    chk("t2_alu", alu_o, 32'h0000_0010);
    chk("t2_rd", 32'(rd_o), 32'd5);
    chk("t2_ctrl", 32'(ctrl_o), 32'd2);
    chk("t2_mem", mem_o, 32'd0);
    chk("t2_instr", instr_o, 32'h0050_82B3);
    chk("t2_req", 32'(mif.mem_req_o), 32'd0);
    tick();
    chk("t2_bubble", 32'(valid_o), 32'd0);

    // 3: load with ack three cycles after the request rises
    drive(1'b1, 1'b0, 4'b1110, 32'h0000_0040, 32'h0, 5'd7, 32'h0400_2383);
    n = 0;
    #1;
    n += int'(stall_o);
    chk("t3_req_c0", 32'(mif.mem_req_o), 32'd0);
    tick();
    n += int'(stall_o);
    chk("t3_req_c1", 32'(mif.mem_req_o), 32'd1);
    chk("t3_addr", mif.mem_addr_o, 32'h0000_0040);
    chk("t3_we", 32'(mif.mem_we_o), 32'd0);
    chk("t3_bubble_c1", 32'(valid_o), 32'd0);
    tick();
    n += int'(stall_o);
    chk("t3_bubble_c2", 32'(valid_o), 32'd0);
    tick();
    n += int'(stall_o);
    chk("t3_ctrl_bubble", 32'(ctrl_o), 32'd0);
    tick();
    mif.mem_ack_i   = 1'b1;
    mif.mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    n += int'(stall_o);
    chk("t3_stall_ack", 32'(stall_o), 32'd0);
    chk("t3_stall_cycles", 32'(n), 32'd4);
    tick();
    mif.mem_ack_i = 1'b0;
    nop();
    chk("t3_valid", 32'(valid_o), 32'd1);
    chk("t3_mem", mem_o, 32'hDEAD_BEEF);
    chk("t3_ctrl", 32'(ctrl_o), 32'd3);
    chk("t3_rd", 32'(rd_o), 32'd7);
    chk("t3_alu", alu_o, 32'h0000_0040);
    chk("t3_instr", instr_o, 32'h0400_2383);
    chk("t3_req_drop", 32'(mif.mem_req_o), 32'd0);

    // 4: store acked in its first request cycle
    drive(1'b1, 1'b0, 4'b0001, 32'h0000_0044, 32'h0000_1234, 5'd0, 32'h0410_2223);
    n = 0;
    #1;
    n += int'(stall_o);
    tick();
    chk("t4_req", 32'(mif.mem_req_o), 32'd1);
    chk("t4_we", 32'(mif.mem_we_o), 32'd1);
    chk("t4_wdata", mif.mem_wdata_o, 32'h0000_1234);
    chk("t4_addr", mif.mem_addr_o, 32'h0000_0044);
    mif.mem_ack_i   = 1'b1;
    mif.mem_rdata_i = 32'hFFFF_0000;
    #1;
    n += int'(stall_o);
    chk("t4_stall_cycles", 32'(n), 32'd1);
    tick();
    mif.mem_ack_i = 1'b0;
    nop();
    chk("t4_valid", 32'(valid_o), 32'd1);
    chk("t4_mem_zero", mem_o, 32'd0);
    chk("t4_ctrl", 32'(ctrl_o), 32'd0);
    chk("t4_req_drop", 32'(mif.mem_req_o), 32'd0);

    // 5a: flushed load in IDLE never reaches memory
    drive(1'b1, 1'b1, 4'b1110, 32'h0000_0048, 32'h0, 5'd8, 32'h0480_2403);
    #1;
    chk("t5_flush_stall", 32'(stall_o), 32'd0);
    tick();
    nop();
    chk("t5_flush_req", 32'(mif.mem_req_o), 32'd0);
    chk("t5_flush_valid", 32'(valid_o), 32'd0);
    tick();
    chk("t5_flush_req2", 32'(mif.mem_req_o), 32'd0);

    // 5b: flush during ACCESS is ignored
    drive(1'b1, 1'b0, 4'b1110, 32'h0000_004C, 32'h0, 5'd9, 32'h04C0_2483);
    tick();
    flush_i = 1'b1;
    #1;
    chk("t5_acc_req", 32'(mif.mem_req_o), 32'd1);
    chk("t5_acc_stall", 32'(stall_o), 32'd1);
    tick();
    flush_i         = 1'b0;
    mif.mem_ack_i   = 1'b1;
    mif.mem_rdata_i = 32'hCAFE_0001;
    tick();
    mif.mem_ack_i = 1'b0;
    nop();
    chk("t5_acc_valid", 32'(valid_o), 32'd1);
    chk("t5_acc_mem", mem_o, 32'hCAFE_0001);
    chk("t5_acc_rd", 32'(rd_o), 32'd9);

    // 6: misaligned load
    drive(1'b1, 1'b0, 4'b1110, 32'h0000_0042, 32'h0, 5'd10, 32'h0420_2503);
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    chk("t6_stall", 32'(stall_o), 32'd0);
    tick();
    nop();
    chk("t6_req", 32'(mif.mem_req_o), 32'd0);
    chk("t6_valid", 32'(valid_o), 32'd1);
    chk("t6_ctrl", 32'(ctrl_o), 32'd1);
    chk("t6_misalign", 32'(misalign_o), 32'd1);
    chk("t6_alu", alu_o, 32'h0000_0042);
    tick();
    chk("t6_misalign_clr", 32'(misalign_o), 32'd0);
`else
    #1;
    chk("t6_stall", 32'(stall_o), 32'd1);
    tick();
    chk("t6_req", 32'(mif.mem_req_o), 32'd1);
    chk("t6_addr", mif.mem_addr_o, 32'h0000_0040);
    mif.mem_ack_i   = 1'b1;
    mif.mem_rdata_i = 32'h0000_0077;
    tick();
    mif.mem_ack_i = 1'b0;
    nop();
    chk("t6_valid", 32'(valid_o), 32'd1);
    chk("t6_mem", mem_o, 32'h0000_0077);
    chk("t6_alu", alu_o, 32'h0000_0042);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
